// File: rtl/demux_o_e_tdm_if.sv
// Serial TDM slot stream: one WIDTH-bit beat per valid cycle, with frame_start marking slot 0.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the receiver must accept every valid beat.
//
// Signals:
//   din          serial slot data
//   din_valid    din carries a slot beat this cycle
//   frame_start  qualifies a valid beat as slot 0 of a new frame
interface demux_o_e_tdm_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_start;

    // The link side drives the stream.
    modport master (
        output din,
        output din_valid,
        output frame_start
    );

    // The demultiplexer side consumes it.
    modport slave (
        input  din,
        input  din_valid,
        input  frame_start
    );
endinterface

// File: rtl/demux_o_e_tdm.sv
// 1-to-8 TDM demultiplexer: collects 8 serial slot beats and publishes them atomically on D0..D7.
// Latency: D0..D7 and frame_valid appear 1 cycle after the closing beat (slot 7, or the parity beat).
// Backpressure: none; every valid beat is consumed, and din_valid gaps simply hold all state.
//
// Ports:
//   clk, rst_n     rising-edge clock and synchronous active-low reset
//   rx             slave side of demux_o_e_tdm_if (din, din_valid, frame_start)
//   D0..D7         registered channel outputs, updated only on frame commit
//   frame_valid    one-cycle pulse when D0..D7 were just updated
//   sync_err       one-cycle pulse when a frame_start beat aborted a partial frame
//   slot           index of the next slot expected
//   busy           high while a frame is being assembled
//   frame_err      (DEMUX_PARITY_EN only) one-cycle pulse when the parity beat mismatched
//
// Build option: define DEMUX_PARITY_EN to add a trailing parity beat (XOR of all 8 slots)
// that must match before the frame is committed.
module demux_o_e_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_o_e_tdm_if.slave   rx,
    output logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] D3,
    output logic [WIDTH-1:0] D4,
    output logic [WIDTH-1:0] D5,
    output logic [WIDTH-1:0] D6,
    output logic [WIDTH-1:0] D7,
    output logic             frame_valid,
    output logic             sync_err,
`ifdef DEMUX_PARITY_EN
    output logic             frame_err,
`endif
    output logic [2:0]       slot,
    output logic             busy
);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
`ifdef DEMUX_PARITY_EN
    localparam logic [1:0] ST_PARITY  = 2'd2;
`endif

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    // Staging registers hold the frame under assembly; outputs only see them at commit.
    logic [WIDTH-1:0] stg   [8];
    logic [WIDTH-1:0] dq    [8];
    logic [WIDTH-1:0] frame_nxt [8];

    // ------------------------------------------------------------------
    // Beat decode
    // ------------------------------------------------------------------
    logic beat;
    logic start_beat;     // frame_start beat: opens a new frame in any state
    logic resync;         // start beat that abandons a partial frame
    logic collect_beat;   // ordinary data beat inside a frame
    logic last_beat;      // data beat landing in slot 7
    logic commit;         // publish frame_nxt onto D0..D7
`ifdef DEMUX_PARITY_EN
    logic             par_beat;
    logic             par_ok;
    logic             frame_bad;
    logic [WIDTH-1:0] par_calc;
`endif

    assign beat         = rx.din_valid;
    assign start_beat   = beat && rx.frame_start;
    assign resync       = start_beat && (state != ST_IDLE);
    assign collect_beat = beat && !rx.frame_start && (state == ST_COLLECT);
    assign last_beat    = collect_beat && (slot == 3'd7);

`ifdef DEMUX_PARITY_EN
    always_comb begin
        par_calc = '0;
        for (int i = 0; i < 8; i++) begin
            par_calc = par_calc ^ stg[i];
        end
    end

    assign par_beat  = beat && !rx.frame_start && (state == ST_PARITY);
    assign par_ok    = (par_calc == rx.din);
    assign commit    = par_beat && par_ok;
    assign frame_bad = par_beat && !par_ok;
`else
    assign commit    = last_beat;
`endif

    // Commit image. Without parity the slot-7 beat is still on din at the commit edge,
    // so it is taken straight from the bus instead of from a staging register.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            frame_nxt[i] = stg[i];
        end
`ifndef DEMUX_PARITY_EN
        frame_nxt[7] = rx.din;
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (start_beat) begin
            state_nxt = ST_COLLECT;
        end else if (last_beat) begin
`ifdef DEMUX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_IDLE;
`endif
        end
`ifdef DEMUX_PARITY_EN
        else if (par_beat) begin
            state_nxt = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Slot counter: a start beat fills slot 0, so the next expected is 1.
    // The only 7->0 wrap is the increment on the slot-7 beat (frame completion).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= 3'd0;
        end else if (start_beat) begin
            slot <= 3'd1;
        end else if (collect_beat) begin
            slot <= slot + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Staging registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                stg[i] <= '0;
            end
        end else if (start_beat) begin
            stg[0] <= rx.din;
        end else if (collect_beat) begin
            stg[slot] <= rx.din;
        end
    end

    // ------------------------------------------------------------------
    // Channel outputs and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                dq[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < 8; i++) begin
                dq[i] <= frame_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= commit;
            sync_err    <= resync;
        end
    end

`ifdef DEMUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_bad;
        end
    end
`endif

    // Busy follows the registered state, so it resets low and drops with the commit edge.
    assign busy = (state != ST_IDLE);

    assign D0 = dq[0];
    assign D1 = dq[1];
    assign D2 = dq[2];
    assign D3 = dq[3];
    assign D4 = dq[4];
    assign D5 = dq[5];
    assign D6 = dq[6];
    assign D7 = dq[7];

endmodule

// File: tb/tb_demux_o_e_tdm.sv
// Directed bench for demux_o_e_tdm with WIDTH=4 and hand-computed expected values.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_demux_o_e_tdm;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
    logic         frame_valid;
    logic         sync_err;
    logic [2:0]   slot;
    logic         busy;
`ifdef DEMUX_PARITY_EN
    logic         frame_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    demux_o_e_tdm_if #(.WIDTH(W)) rx_if ();

    demux_o_e_tdm #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx_if.slave),
        .D0          (D0),
        .D1          (D1),
        .D2          (D2),
        .D3          (D3),
        .D4          (D4),
        .D5          (D5),
        .D6          (D6),
        .D7          (D7),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
`ifdef DEMUX_PARITY_EN
        .frame_err   (frame_err),
`endif
        .slot        (slot),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One valid beat, captured on the next rising edge; returns 1 ns after that edge.
    task automatic send(input logic fs, input logic [W-1:0] d);
        rx_if.din         = d;
        rx_if.din_valid   = 1'b1;
        rx_if.frame_start = fs;
        @(posedge clk);
        #1;
        rx_if.din_valid   = 1'b0;
        rx_if.frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_if.din_valid   = 1'b0;
        rx_if.frame_start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Full frame: frame_start on beat 0, plus a correct parity beat when enabled.
    task automatic send_frame(input logic [W-1:0] d [8]);
        logic [W-1:0] par;
        par = '0;
        for (int i = 0; i < 8; i++) begin
            send(i == 0, d[i]);
            par = par ^ d[i];
        end
`ifdef DEMUX_PARITY_EN
        send(1'b0, par);
`endif
    endtask

    task automatic check_d(input string tag, input logic [W-1:0] e [8]);
        check({tag, ".D0"}, D0, e[0]);
        check({tag, ".D1"}, D1, e[1]);
        check({tag, ".D2"}, D2, e[2]);
        check({tag, ".D3"}, D3, e[3]);
        check({tag, ".D4"}, D4, e[4]);
        check({tag, ".D5"}, D5, e[5]);
        check({tag, ".D6"}, D6, e[6]);
        check({tag, ".D7"}, D7, e[7]);
    endtask

    logic [W-1:0] f_a   [8];
    logic [W-1:0] f_f   [8];
    logic [W-1:0] f_8   [8];
    logic [W-1:0] f_0   [8];
`ifdef DEMUX_PARITY_EN
    logic [W-1:0] f_p   [8];
`endif

    initial begin
        f_a = '{4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        f_f = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        f_8 = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        f_0 = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`ifdef DEMUX_PARITY_EN
        f_p = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
`endif

        rst_n             = 1'b0;
        rx_if.din         = '0;
        rx_if.din_valid   = 1'b0;
        rx_if.frame_start = 1'b0;
        idle(2);

        // Reset state
        check_d("rst", f_0);
        check("rst.frame_valid", frame_valid, 0);
        check("rst.sync_err", sync_err, 0);
        check("rst.slot", slot, 0);
        check("rst.busy", busy, 0);
`ifdef DEMUX_PARITY_EN
        check("rst.frame_err", frame_err, 0);
`endif
        rst_n = 1'b1;

        // Back-to-back frame A,1..7
        send(1'b1, 4'hA);
        check("f1.busy_after_start", busy, 1);
        check("f1.slot_after_start", slot, 1);
        for (int i = 1; i < 7; i++) send(1'b0, 4'(i));
        check("f1.slot_before_last", slot, 7);
        check("f1.D0_before_commit", D0, 4'h0);
        check("f1.fv_before_commit", frame_valid, 0);
        send(1'b0, 4'h7);
`ifdef DEMUX_PARITY_EN
        check("f1.par_wait_busy", busy, 1);
        check("f1.par_wait_D1", D1, 4'h0);
        check("f1.par_wait_fv", frame_valid, 0);
        send(1'b0, 4'hA);   // A ^ 1 ^ .. ^ 7 = A
`endif
        check_d("f1", f_a);
        check("f1.frame_valid", frame_valid, 1);
        check("f1.slot", slot, 0);
        check("f1.busy", busy, 0);
        check("f1.sync_err", sync_err, 0);
        idle(1);
        check("f1.fv_one_cycle", frame_valid, 0);

        // Gapped frame after reset: outputs hold 0 until the commit edge
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            send(i == 0, f_a[i]);
            if (i == 3) begin
                check("gap.D0_held", D0, 4'h0);
                check("gap.slot4", slot, 4);
            end
            if (i < 7) idle(3);
            if (i == 3) begin
                check("gap.slot_held", slot, 4);
                check("gap.fv_low", frame_valid, 0);
            end
        end
`ifdef DEMUX_PARITY_EN
        idle(3);
        send(1'b0, 4'hA);
`endif
        check_d("gap", f_a);
        check("gap.frame_valid", frame_valid, 1);
        idle(1);

        // Resync: 4 beats, then a new frame of all F
        send(1'b1, 4'h3);
        send(1'b0, 4'h3);
        send(1'b0, 4'h3);
        send(1'b0, 4'h3);
        send(1'b1, 4'hF);
        check("rs.sync_err", sync_err, 1);
        check("rs.slot", slot, 1);
        check("rs.busy", busy, 1);
        check("rs.fv", frame_valid, 0);
        check("rs.D0_held", D0, 4'hA);
        idle(1);
        check("rs.sync_err_one_cycle", sync_err, 0);
        for (int i = 1; i < 8; i++) send(1'b0, 4'hF);
`ifdef DEMUX_PARITY_EN
        send(1'b0, 4'h0);
`endif
        check_d("rs", f_f);
        check("rs.frame_valid", frame_valid, 1);
        check("rs.no_sync_err_at_commit", sync_err, 0);
        idle(1);

        // Orphan beats in IDLE are dropped silently
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 4'h5);
            check("orph.busy", busy, 0);
            check("orph.slot", slot, 0);
            check("orph.fv", frame_valid, 0);
            check("orph.se", sync_err, 0);
            check("orph.D0", D0, 4'hF);
        end

        // Mid-frame reset after 5 beats
        send(1'b1, 4'h1);
        for (int i = 2; i < 6; i++) send(1'b0, 4'(i));
        check("mr.slot_before", slot, 5);
        pulse_reset();
        check_d("mr.rst", f_0);
        check("mr.slot", slot, 0);
        check("mr.busy", busy, 0);
        check("mr.fv", frame_valid, 0);
        check("mr.se", sync_err, 0);
        send_frame(f_8);
        check_d("mr.next", f_8);
        check("mr.next_fv", frame_valid, 1);
        check("mr.next_se", sync_err, 0);
        idle(1);

`ifdef DEMUX_PARITY_EN
        // Parity: 1..8 XORs to 8
        for (int i = 0; i < 8; i++) send(i == 0, f_p[i]);
        send(1'b0, 4'h8);
        check_d("par.ok", f_p);
        check("par.ok_fv", frame_valid, 1);
        check("par.ok_fe", frame_err, 0);
        idle(1);
        pulse_reset();
        for (int i = 0; i < 8; i++) send(i == 0, f_p[i]);
        send(1'b0, 4'h0);
        check("par.bad_fe", frame_err, 1);
        check("par.bad_fv", frame_valid, 0);
        check("par.bad_busy", busy, 0);
        check_d("par.bad", f_0);
        idle(1);
        check("par.fe_one_cycle", frame_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
